// File: rtl/result_bcd_display.sv
// Sequential double-dabble converter: turns the signed datapath result into a sign flag plus
// packed BCD magnitude, restarting by itself whenever the observed value changes.
module result_bcd_display #(
    parameter int WIDTH  = 28,
    parameter int DIGITS = 9
) (
    input  logic                clockDisplay,
    input  logic                resetDisplay,
    input  logic [WIDTH-1:0]    valueDisplay,
    output logic [4*DIGITS-1:0] digitsDisplay,
    output logic                signDisplay,
    output logic                busyDisplay,
    output logic                readyDisplay
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state;
    state_t              state_next;
    logic [WIDTH-1:0]    last_value;
    logic [WIDTH-1:0]    bin_reg;
    logic [WIDTH-1:0]    magnitude;
    logic [4*DIGITS-1:0] bcd_reg;
    logic [4*DIGITS-1:0] bcd_adj;
    logic [CW-1:0]       count;
    logic                first_flag;
    logic                sign_reg;
    logic                start;

    // No valid strobe exists upstream, so any difference from the last converted value starts a run.
    assign start = (valueDisplay != last_value) || first_flag;

    // Full-width negate keeps -2^(WIDTH-1) correct as an unsigned magnitude.
    assign magnitude = valueDisplay[WIDTH-1] ? (~valueDisplay + WIDTH'(1)) : valueDisplay;

    // NOTE: every variable gets a default before any branch, so always_comb never infers a latch.
    always_comb begin
        bcd_adj = bcd_reg;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_reg[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_reg[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (count == CW'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clockDisplay) begin
        if (resetDisplay) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: the working registers are few and cheap, so they are reset along with the outputs;
    // a reset mid-run therefore leaves nothing stale behind.
    always_ff @(posedge clockDisplay) begin
        if (resetDisplay) begin
            last_value    <= '0;
            first_flag    <= 1'b1;
            sign_reg      <= 1'b0;
            bin_reg       <= '0;
            bcd_reg       <= '0;
            count         <= '0;
            digitsDisplay <= '0;
            signDisplay   <= 1'b0;
            busyDisplay   <= 1'b0;
            readyDisplay  <= 1'b0;
        end else begin
            readyDisplay <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        last_value  <= valueDisplay;
                        first_flag  <= 1'b0;
                        sign_reg    <= valueDisplay[WIDTH-1];
                        bin_reg     <= magnitude;
                        bcd_reg     <= '0;
                        count       <= CW'(WIDTH);
                        busyDisplay <= 1'b1;
                    end
                end
                SHIFT: begin
                    {bcd_reg, bin_reg} <= {bcd_adj, bin_reg} << 1;
                    count              <= count - CW'(1);
                end
                DONE: begin
                    digitsDisplay <= bcd_reg;
                    signDisplay   <= sign_reg;
                    readyDisplay  <= 1'b1;
                    busyDisplay   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
